imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator. Sits between fetch and decode.
- Accepts one instruction per cycle on a valid/ready handshake. Extracts the sign/zero-extended immediate for every RV32I/RV64I format and classifies the format.
- Flags illegal opcodes and precomputes pc+imm for control-flow targets and AUIPC.
- Results are registered with a 2-entry skid buffer, so back-pressure never drops or reorders instructions.

---
 rtl/imm_pkg.sv | 34 +++
 rtl/imm_extract.sv | 133 +++++++++++++
 rtl/imm_gen_pipe.sv | 129 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg
// Shared constants for the pipelined immediate generator:
//   - RV32I/RV64I major opcodes recognised by the extractor
//   - format codes reported on out_fmt
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } fmt_e;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRX = 3'b101;

endpackage

// File: rtl/imm_extract.sv
// imm_extract
// Purely combinational immediate decoder.
//   instr     in   32     instruction word
//   imm_sel   in   1      0 = no immediate wanted; all outputs forced to neutral
//   imm       out  XLEN   sign/zero-extended immediate
//   fmt       out  3      format code (imm_pkg::fmt_e)
//   illegal   out  1      opcode outside the accepted set
//   is_pcrel  out  1      entry needs pc+imm (B, J, AUIPC)
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic [31:0]     instr,
    input  logic            imm_sel,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic            is_pcrel
);

    // The 32-bit-word ops only make sense on a 64-bit datapath.
    localparam bit RV64_EN = RV64_OPS && (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    fmt_e        fmt_v;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRX);

    // All formats are first built as 32-bit sign-extended values, then
    // widened to XLEN in one place.
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        imm      = '0;
        fmt_v    = FMT_NONE;
        illegal  = 1'b0;
        is_pcrel = 1'b0;

        case (opcode)
            OP_IMM: begin
                if (is_shift) begin
                    // instr[30] selects SRA vs SRL and is not part of shamt.
                    fmt_v = FMT_SH;
                    imm   = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                end else begin
                    fmt_v = FMT_I;
                    imm   = sext32(imm_i);
                end
            end
            OP_IMM_32: begin
                if (RV64_EN) begin
                    if (is_shift) begin
                        fmt_v = FMT_SH;
                        imm   = XLEN'(instr[24:20]);
                    end else begin
                        fmt_v = FMT_I;
                        imm   = sext32(imm_i);
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            LOAD, JALR, SYSTEM, MISC_MEM: begin
                fmt_v = FMT_I;
                imm   = sext32(imm_i);
            end
            STORE: begin
                fmt_v = FMT_S;
                imm   = sext32(imm_s);
            end
            BRANCH: begin
                fmt_v    = FMT_B;
                imm      = sext32(imm_b);
                is_pcrel = 1'b1;
            end
            JAL: begin
                fmt_v    = FMT_J;
                imm      = sext32(imm_j);
                is_pcrel = 1'b1;
            end
            LUI: begin
                fmt_v = FMT_U;
                imm   = sext32(imm_u);
            end
            AUIPC: begin
                fmt_v    = FMT_U;
                imm      = sext32(imm_u);
                is_pcrel = 1'b1;
            end
            OP: begin
                fmt_v = FMT_NONE;
            end
            OP_32: begin
                if (!RV64_EN) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        // Immediate not wanted: the entry passes through with neutral fields.
        if (!imm_sel) begin
            imm      = '0;
            fmt_v    = FMT_NONE;
            illegal  = 1'b0;
            is_pcrel = 1'b0;
        end
    end

    assign fmt = fmt_v;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined immediate generator between fetch and decode. Decodes the
// immediate on the input side, adds pc for pc-relative formats, and
// registers the result into an output register backed by one skid entry.
//   clk          in   1      clock
//   rst_n        in   1      async active-low reset
//   flush        in   1      sync kill of all buffered entries (wins over transfers)
//   in_valid     in   1      input entry valid
//   in_ready     out  1      input can be accepted (registered, = !skid_valid)
//   in_instr     in   32     instruction word
//   in_pc        in   XLEN   pc of the instruction
//   in_imm_sel   in   1      0 = immediate not required
//   out_valid    out  1      output entry valid
//   out_ready    in   1      downstream accepts
//   out_imm      out  XLEN   extended immediate
//   out_fmt      out  3      format code
//   out_target   out  XLEN   pc+imm for B/J/AUIPC, else 0
//   out_illegal  out  1      opcode not in the legal set
//   out_instr    out  32     instruction, passed through
//   out_pc       out  XLEN   pc, passed through
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_fmt;
    logic            ext_illegal;
    logic            ext_pcrel;
    entry_t          in_entry;
    entry_t          out_q;
    entry_t          skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            in_xfer;
    logic            out_free;

    imm_extract #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_extract (
        .instr    (in_instr),
        .imm_sel  (in_imm_sel),
        .imm      (ext_imm),
        .fmt      (ext_fmt),
        .illegal  (ext_illegal),
        .is_pcrel (ext_pcrel)
    );

    always_comb begin
        in_entry.imm     = ext_imm;
        in_entry.fmt     = ext_fmt;
        // Natural XLEN-bit wrap gives the modulo 2^XLEN target.
        in_entry.target  = ext_pcrel ? (in_pc + ext_imm) : '0;
        in_entry.illegal = ext_illegal;
        in_entry.instr   = in_instr;
        in_entry.pc      = in_pc;
    end

    assign in_ready = ~skid_valid_q;
    assign in_xfer  = in_valid && in_ready;
    // Output register can take a new entry when empty or draining this cycle.
    assign out_free = ~out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            // in_ready is low whenever skid is occupied, so a skid entry and
            // a new input never compete for the output register.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_xfer) begin
                out_q       <= in_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                           F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    logic        a_in_valid, a_in_ready, a_in_sel, a_out_valid, a_out_ready, a_out_ill;
    logic [31:0] a_in_instr, a_in_pc, a_out_imm, a_out_tgt, a_out_instr, a_out_pc;
    logic [2:0]  a_out_fmt;

    logic        b_in_valid, b_in_ready, b_in_sel, b_out_valid, b_out_ready, b_out_ill;
    logic [31:0] b_in_instr, b_out_instr;
    logic [63:0] b_in_pc, b_out_imm, b_out_tgt, b_out_pc;
    logic [2:0]  b_out_fmt;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .in_pc(a_in_pc), .in_imm_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_target(a_out_tgt), .out_illegal(a_out_ill),
        .out_instr(a_out_instr), .out_pc(a_out_pc)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .in_pc(b_in_pc), .in_imm_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_target(b_out_tgt), .out_illegal(b_out_ill),
        .out_instr(b_out_instr), .out_pc(b_out_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d32_unexpected: got instr %h, expected no output", a_out_instr);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("d32_instr",  {32'b0, a_out_instr}, {32'b0, e.instr});
                chk("d32_imm",    {32'b0, a_out_imm},   e.imm);
                chk("d32_fmt",    {61'b0, a_out_fmt},   {61'b0, e.fmt});
                chk("d32_target", {32'b0, a_out_tgt},   e.tgt);
                chk("d32_illegal",{63'b0, a_out_ill},   {63'b0, e.ill});
                chk("d32_pc",     {32'b0, a_out_pc},    e.pc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (q64.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d64_unexpected: got instr %h, expected no output", b_out_instr);
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk("d64_instr",  {32'b0, b_out_instr}, {32'b0, e.instr});
                chk("d64_imm",    b_out_imm,            e.imm);
                chk("d64_fmt",    {61'b0, b_out_fmt},   {61'b0, e.fmt});
                chk("d64_target", b_out_tgt,            e.tgt);
                chk("d64_illegal",{63'b0, b_out_ill},   {63'b0, e.ill});
                chk("d64_pc",     b_out_pc,             e.pc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit w64, input logic [31:0] instr, input logic [63:0] pc,
                        input logic sel, input logic [63:0] imm, input logic [2:0] fmt,
                        input logic [63:0] tgt, input logic ill);
        exp_t e;
        bit   ok;
        bit   rdy;
        ok = 1'b0;
        e.imm = imm; e.fmt = fmt; e.tgt = tgt; e.ill = ill; e.instr = instr; e.pc = pc;
        if (w64) begin
            b_in_valid = 1'b1; b_in_instr = instr; b_in_pc = pc; b_in_sel = sel;
        end else begin
            a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc[31:0]; a_in_sel = sel;
        end
        for (int n = 0; n < 50 && !ok; n++) begin
            rdy = w64 ? b_in_ready : a_in_ready;
            if (rdy) begin
                ok = 1'b1;
                if (w64) q64.push_back(e);
                else     q32.push_back(e);
            end
            @(posedge clk); #1;
        end
        if (w64) b_in_valid = 1'b0;
        else     a_in_valid = 1'b0;
        chk("send_accepted", {63'b0, ok}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q32.size() != 0 || q64.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_q32_empty", q32.size(), 64'd0);
        chk("drain_q64_empty", q64.size(), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        a_in_valid = 0; a_in_instr = 0; a_in_pc = 0; a_in_sel = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_in_sel = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_in_ready",  {63'b0, a_in_ready},  64'd1);
        chk("rst_out_imm",   {32'b0, a_out_imm},   64'd0);
        chk("rst_out_fmt",   {61'b0, a_out_fmt},   {61'b0, F_NONE});
        chk("rst64_in_ready",{63'b0, b_in_ready},  64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // XLEN=32 directed vectors, out_ready held high.
        send(0, 32'hFFF00093, 64'h0,    1, 64'hFFFFFFFF, F_I,    64'h0,   0);
        send(0, 32'hFE000EE3, 64'h100,  1, 64'hFFFFFFFC, F_B,    64'hFC,  0);
        send(0, 32'h0000007F, 64'h104,  1, 64'h0,        F_NONE, 64'h0,   1);
        send(0, 32'h0000007F, 64'h108,  0, 64'h0,        F_NONE, 64'h0,   0);
        send(0, 32'hFE20AC23, 64'h10C,  1, 64'hFFFFFFF8, F_S,    64'h0,   0);
        send(0, 32'h0080006F, 64'h200,  1, 64'h8,        F_J,    64'h208, 0);
        send(0, 32'h12345037, 64'h204,  1, 64'h12345000, F_U,    64'h0,   0);
        send(0, 32'h00309093, 64'h208,  1, 64'h3,        F_SH,   64'h0,   0);
        send(0, 32'h4030D093, 64'h20C,  1, 64'h3,        F_SH,   64'h0,   0);
        send(0, 32'h00000033, 64'h210,  1, 64'h0,        F_NONE, 64'h0,   0);
        send(0, 32'h00001017, 64'h1000, 1, 64'h1000,     F_U,    64'h2000,0);
        send(0, 32'h00C08067, 64'h214,  1, 64'hC,        F_I,    64'h0,   0);
        send(0, 32'h0000001B, 64'h218,  1, 64'h0,        F_NONE, 64'h0,   1);
        send(0, 32'hFE000EE3, 64'h100,  0, 64'h0,        F_NONE, 64'h0,   0);
        drain();

        // Skid: A held on output, B into skid, C stalled until release.
        a_out_ready = 1'b0;
        send(0, 32'hFFF00093, 64'h10, 1, 64'hFFFFFFFF, F_I,  64'h0, 0);
        send(0, 32'h00309093, 64'h14, 1, 64'h3,        F_SH, 64'h0, 0);
        chk("in_ready_after_B", {63'b0, a_in_ready}, 64'd0);
        fork
            send(0, 32'h12345037, 64'h18, 1, 64'h12345000, F_U, 64'h0, 0);
            begin
                for (int i = 0; i < 3; i++) begin
                    chk("hold_A_instr", {32'b0, a_out_instr}, 64'hFFF00093);
                    chk("hold_A_valid", {63'b0, a_out_valid}, 64'd1);
                    @(posedge clk); #1;
                end
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two entries buffered and a same-cycle input.
        a_out_ready = 1'b0;
        send(0, 32'h00C08067, 64'h20, 1, 64'hC, F_I, 64'h0, 0);
        send(0, 32'h00000033, 64'h24, 1, 64'h0, F_NONE, 64'h0, 0);
        a_in_valid = 1'b1; a_in_instr = 32'h00000013; a_in_pc = 32'h28; a_in_sel = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; a_in_valid = 1'b0;
        q32.delete();
        chk("flush_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("flush_in_ready",  {63'b0, a_in_ready},  64'd1);
        a_out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("flush_no_output", {63'b0, a_out_valid}, 64'd0);

        // Reset asserted mid-stall.
        a_out_ready = 1'b0;
        send(0, 32'hFFF00093, 64'h30, 1, 64'hFFFFFFFF, F_I, 64'h0, 0);
        send(0, 32'hFE000EE3, 64'h34, 1, 64'hFFFFFFFC, F_B, 64'h30, 0);
        #2 rst_n = 1'b0;
        #1;
        q32.delete();
        chk("rst_mid_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_mid_in_ready",  {63'b0, a_in_ready},  64'd1);
        chk("rst_mid_out_imm",   {32'b0, a_out_imm},   64'd0);
        chk("rst_mid_out_instr", {32'b0, a_out_instr}, 64'd0);
        chk("rst_mid_out_pc",    {32'b0, a_out_pc},    64'd0);
        chk("rst_mid_out_tgt",   {32'b0, a_out_tgt},   64'd0);
        a_out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // XLEN=64 with RV64 word ops.
        send(1, 32'h800000B7, 64'h0,                 1, 64'hFFFFFFFF80000000, F_U,    64'h0, 0);
        send(1, 32'h43F0D093, 64'h4,                 1, 64'h3F,               F_SH,   64'h0, 0);
        send(1, 32'h00001017, 64'hFFFFFFFFFFFFF000,  1, 64'h1000,             F_U,    64'h0, 0);
        send(1, 32'h03F0909B, 64'h8,                 1, 64'h1F,               F_SH,   64'h0, 0);
        send(1, 32'h0000003B, 64'hC,                 1, 64'h0,                F_NONE, 64'h0, 0);
        send(1, 32'hFE000EE3, 64'h100,               1, 64'hFFFFFFFFFFFFFFFC, F_B,    64'hFC,0);
        send(1, 32'h0000007F, 64'h10,                1, 64'h0,                F_NONE, 64'h0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
